// File: rtl/spi_adc_slave_pkg.sv
// Shared SPI constants for the ADC slave and its master: frame geometry, timing limits, FSM encoding.
package spi_adc_slave_pkg;

  localparam int SPI_DATA_W     = 8;
  localparam int SPI_LEAD_BITS  = 3;
  localparam int SPI_FRAME_BITS = 15;

  // Master side: sclk idles high, half-period must leave room for the 3-clk output path.
  localparam logic SPI_SCLK_IDLE     = 1'b1;
  localparam int   SPI_SCLK_HALF_MIN = 6;
  localparam int   SPI_SDATA_LAT_MAX = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEAD = 2'd1,
    ST_DATA = 2'd2,
    ST_TAIL = 2'd3
  } adc_state_e;

endpackage

// File: rtl/spi_adc_slave_sync_edge.sv
// Two-flop synchronizer for an idle-high async input, plus a third stage for rise/fall pulses.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  // stg[0], stg[1] synchronize; stg[2] holds the previous synchronized level.
  logic [2:0] stg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stg <= 3'b111;
    end else begin
      stg <= {stg[1:0], din};
    end
  end

  assign rise = stg[1] & ~stg[2];
  assign fall = ~stg[1] & stg[2];

endmodule

// File: rtl/spi_adc_slave.sv
// SPI ADC-style slave: shifts LEAD zeros, a DATA_W word MSB first, then zeros; sdata moves on sclk falls.
module spi_adc_slave
  import spi_adc_slave_pkg::*;
#(
  parameter int DATA_W     = SPI_DATA_W,
  parameter int LEAD_BITS  = SPI_LEAD_BITS,
  parameter int FRAME_BITS = SPI_FRAME_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  output logic              sdata,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              frame_done,
  output logic              underrun,
  output logic              busy
);

  localparam int            CW        = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LEAD_END  = CW'(LEAD_BITS);
  localparam logic [CW-1:0] DATA_END  = CW'(LEAD_BITS + DATA_W);
  localparam logic [CW-1:0] FRAME_END = CW'(FRAME_BITS);
  localparam logic [CW-1:0] LAST_RISE = CW'(FRAME_BITS - 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  sync_edge u_sync_sclk (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  sync_edge u_sync_cs (
    .clk  (clk),
    .rst  (rst),
    .din  (cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  adc_state_e        state, state_nxt;
  logic [CW-1:0]     fcnt, rcnt;
  logic [DATA_W-1:0] shreg, pend_dat;
  logic              pend_full, cs_low;
  logic              start, shift, drop, done_nxt, sdata_nxt;
  logic              accept;

  assign accept   = tx_valid & ~pend_full;
  assign tx_ready = ~pend_full;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    shift     = 1'b0;
    drop      = 1'b0;
    done_nxt  = 1'b0;
    sdata_nxt = sdata;
    case (state)
      ST_IDLE: begin
        sdata_nxt = 1'b0;
        if (cs_fall) begin
          state_nxt = ST_LEAD;
          start     = 1'b1;
        end
      end
      default: begin
        if (cs_rise) begin
          // Master released the slave early: abandon the frame and its word.
          state_nxt = ST_IDLE;
          sdata_nxt = 1'b0;
          drop      = 1'b1;
        end else if (state == ST_TAIL && sclk_rise && rcnt == LAST_RISE) begin
          state_nxt = ST_IDLE;
          sdata_nxt = 1'b0;
          done_nxt  = 1'b1;
        end else if (sclk_fall && cs_low) begin
          // fcnt still holds the count before this edge.
          if (state == ST_LEAD) begin
            if (fcnt == LEAD_END) begin
              state_nxt = ST_DATA;
              sdata_nxt = shreg[DATA_W-1];
              shift     = 1'b1;
            end else begin
              sdata_nxt = 1'b0;
            end
          end else if (state == ST_DATA) begin
            if (fcnt == DATA_END) begin
              state_nxt = ST_TAIL;
              sdata_nxt = 1'b0;
            end else begin
              sdata_nxt = shreg[DATA_W-1];
              shift     = 1'b1;
            end
          end else begin
            sdata_nxt = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt       <= '0;
      rcnt       <= '0;
      shreg      <= '0;
      pend_dat   <= '0;
      pend_full  <= 1'b0;
      cs_low     <= 1'b0;
      sdata      <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      sdata      <= sdata_nxt;
      frame_done <= done_nxt;
      underrun   <= start & ~pend_full;

      if (cs_fall) begin
        cs_low <= 1'b1;
      end else if (cs_rise) begin
        cs_low <= 1'b0;
      end

      if (start) begin
        fcnt <= '0;
      end else if (sclk_fall && cs_low && fcnt != FRAME_END) begin
        fcnt <= fcnt + CW'(1);
      end

      if (start) begin
        rcnt <= '0;
      end else if (state != ST_IDLE && sclk_rise && rcnt != FRAME_END) begin
        rcnt <= rcnt + CW'(1);
      end

      if (start) begin
        shreg <= pend_full ? pend_dat : '0;
      end else if (drop) begin
        shreg <= '0;
      end else if (shift) begin
        shreg <= shreg << 1;
      end

      // A word accepted on the start cycle lands in pend, never in this frame.
      if (start && pend_full) begin
        pend_full <= 1'b0;
      end else if (accept) begin
        pend_full <= 1'b1;
        pend_dat  <= tx_data;
      end
    end
  end

endmodule

// File: tb/tb_spi_adc_slave.sv
// Directed bench: a behavioural SPI master drives 25-clk sclk periods and checks captured frames.
module tb_spi_adc_slave;

  logic       clk, rst, sclk, cs_n, sdata;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, frame_done, underrun, busy;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int under_cnt = 0;

  spi_adc_slave dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .cs_n       (cs_n),
    .sdata      (sdata),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .frame_done (frame_done),
    .underrun   (underrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && frame_done) done_cnt++;
    if (!rst && underrun) under_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] word;
    bit         preload;
    logic [7:0] exp_word;
    bit         exp_under;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic offer(input logic [7:0] w);
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    for (int i = 0; i < 200 && !tx_ready; i++) @(negedge clk);
    chk("offer_ready", {31'd0, tx_ready}, 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic frame_begin();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  // Master samples sdata just before each sclk rise; bits[0] is the latest sample.
  task automatic frame_bits(input int nfall, input bit end_low, output logic [14:0] bits);
    logic [14:0] b;
    b = '0;
    for (int i = 1; i <= nfall; i++) begin
      sclk = 1'b0;
      #120;
      if (!(end_low && i == nfall)) begin
        b = {b[13:0], sdata};
        sclk = 1'b1;
        #130;
      end
    end
    bits = b;
  endtask

  task automatic frame_end();
    #100;
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  vec_t        vecs [6];
  logic [14:0] bits;
  int          d0, u0;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 8'h3C, 1'b0};
    vecs[4] = '{8'hEE, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h81, 1'b1, 8'h81, 1'b0};

    rst = 1'b1; cs_n = 1'b1; sclk = 1'b1; tx_data = '0; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sdata", {31'd0, sdata}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].preload) begin
        offer(vecs[v].word);
        chk($sformatf("v%0d_ready_pending", v), {31'd0, tx_ready}, 32'd0);
      end
      d0 = done_cnt;
      u0 = under_cnt;
      frame_begin();
      chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd1);
      chk($sformatf("v%0d_ready_after_start", v), {31'd0, tx_ready}, 32'd1);
      frame_bits(15, 1'b0, bits);
      frame_end();
      chk($sformatf("v%0d_payload", v), {24'd0, bits[11:4]}, {24'd0, vecs[v].exp_word});
      chk($sformatf("v%0d_lead", v), {29'd0, bits[14:12]}, 32'd0);
      chk($sformatf("v%0d_tail", v), {28'd0, bits[3:0]}, 32'd0);
      chk($sformatf("v%0d_done", v), done_cnt - d0, 32'd1);
      chk($sformatf("v%0d_underrun", v), under_cnt - u0, {31'd0, vecs[v].exp_under});
      chk($sformatf("v%0d_idle", v), {30'd0, busy, sdata}, 32'd0);
    end

    // cs_n released after falling edge 6: frame dropped, word discarded.
    offer(8'h77);
    d0 = done_cnt;
    frame_begin();
    frame_bits(6, 1'b1, bits);
    cs_n = 1'b1;
    #50;
    sclk = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_partial_bits", {27'd0, bits[4:0]}, 32'h01);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_sdata", {31'd0, sdata}, 32'd0);
    chk("abort_no_done", done_cnt - d0, 32'd0);
    offer(8'h99);
    d0 = done_cnt;
    frame_begin();
    frame_bits(15, 1'b0, bits);
    frame_end();
    chk("after_abort_payload", {24'd0, bits[11:4]}, 32'h99);
    chk("after_abort_done", done_cnt - d0, 32'd1);

    // Word offered on the exact frame-start clk must wait for the next frame.
    u0 = under_cnt;
    @(negedge clk);
    cs_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("late_word_pending", {31'd0, tx_ready}, 32'd0);
    chk("late_word_underrun", under_cnt - u0, 32'd1);
    frame_bits(15, 1'b0, bits);
    frame_end();
    chk("late_word_cur_payload", {24'd0, bits[11:4]}, 32'h00);
    u0 = under_cnt;
    frame_begin();
    frame_bits(15, 1'b0, bits);
    frame_end();
    chk("late_word_next_payload", {24'd0, bits[11:4]}, 32'hC3);
    chk("late_word_next_underrun", under_cnt - u0, 32'd0);

    // Reset pulsed mid-DATA.
    offer(8'h11);
    d0 = done_cnt;
    frame_begin();
    frame_bits(7, 1'b1, bits);
    chk("mid_rst_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b1;
    @(negedge clk);
    chk("mid_rst_sdata", {31'd0, sdata}, 32'd0);
    chk("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("mid_rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("mid_rst_underrun", {31'd0, underrun}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_rst_stays_idle", {31'd0, busy}, 32'd0);
    chk("mid_rst_no_done", done_cnt - d0, 32'd0);
    offer(8'h5A);
    d0 = done_cnt;
    u0 = under_cnt;
    frame_begin();
    frame_bits(15, 1'b0, bits);
    frame_end();
    chk("post_rst_payload", {24'd0, bits[11:4]}, 32'h5A);
    chk("post_rst_done", done_cnt - d0, 32'd1);
    chk("post_rst_underrun", under_cnt - u0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
